// File: rtl/stack_reader.sv
// stack_reader: drains an external stack into a first-word-fall-through
// output FIFO. A drain waits until the FIFO has room for the whole stack,
// streams it out, tags the last word, then clears the stack.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  S_IDLE    | waiting for a start pulse
//  S_WAIT    | drain accepted; waiting for FIFO room (or empty-stack bypass)
//  S_REQ     | one-cycle stream trigger to the stack; latch entry count
//  S_CAPTURE | push one stack word per cycle into the FIFO, N cycles
//  S_CLEAR   | one-cycle completion; clears the stack if anything was read
module stack_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 24,
    localparam int CW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_drain_done,
    output logic                  o_err,
    input  logic                  i_stk_empty,
    input  logic [CW-1:0]         i_stk_active_entries,
    input  logic [DATA_WIDTH-1:0] i_stk_dout,
    input  logic                  i_stk_done,
    output logic                  o_stk_stream_out,
    output logic                  o_stk_clear,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_last,
    output logic                  o_m_valid,
    input  logic                  i_m_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_REQ     = 3'd2,
        S_CAPTURE = 3'd3,
        S_CLEAR   = 3'd4
    } state_t;

    localparam logic [CW:0]   FULL_CNT  = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] PTR_LAST  = CW'(DEPTH - 1);
    localparam logic [CW+1:0] ROOM_MAX  = (CW + 2)'(DEPTH);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cap_rem;
    logic                  r_nonempty;
    logic                  r_err;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic [CW:0]           r_count;

    logic                  w_cap_last;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_overflow;
    logic                  w_done_bad;
    logic [CW+1:0]         w_need_total;
    logic                  w_fits;
    logic [DATA_WIDTH:0]   w_head;

    // Remaining-capture down-counter reaches zero on the Nth capture cycle.
    assign w_cap_last   = (r_cap_rem == '0);
    assign w_push       = (r_state == S_CAPTURE);
    assign w_pop        = o_m_valid & i_m_ready;
    assign w_full       = (r_count == FULL_CNT);
    // A push into a full FIFO still lands if the head is leaving the same cycle.
    assign w_push_ok    = w_push & (~w_full | w_pop);
    assign w_overflow   = w_push & w_full & ~w_pop;
    assign w_done_bad   = w_push & (w_cap_last ? ~i_stk_done : i_stk_done);

    // Room check counts the whole stack (active entries + 1) against FIFO space.
    assign w_need_total = {1'b0, r_count} + {2'b00, i_stk_active_entries} + (CW + 2)'(1);
    assign w_fits       = (w_need_total <= ROOM_MAX);

    assign w_head       = r_mem[r_rd_ptr];
    assign o_m_valid    = (r_count != '0);
    assign o_m_data     = o_m_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign o_m_last     = o_m_valid & w_head[DATA_WIDTH];
    assign o_err        = r_err;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt      = r_state;
        o_busy           = 1'b1;
        o_stk_stream_out = 1'b0;
        o_drain_done     = 1'b0;
        o_stk_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stk_empty) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_fits) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                o_stk_stream_out = 1'b1;
                w_state_nxt      = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_cap_last) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                o_drain_done = 1'b1;
                o_stk_clear  = r_nonempty;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture length latch and countdown; remembers whether this drain read anything.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap_rem  <= '0;
            r_nonempty <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_nonempty <= ~i_stk_empty;
            end
            if (r_state == S_REQ) begin
                r_cap_rem <= i_stk_active_entries;
            end else if (w_push && !w_cap_last) begin
                r_cap_rem <= r_cap_rem - CW'(1);
            end
        end
    end

    // Sticky protocol error: misplaced stk_done or a dropped push.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_done_bad || w_overflow) begin
            r_err <= 1'b1;
        end
    end

    // FIFO storage; contents need no reset because outputs are gated by count.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {w_cap_last, i_stk_dout};
        end
    end

    // FIFO pointers (wrap at DEPTH-1) and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + CW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + CW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (CW + 1)'(1);
                2'b01:   r_count <= r_count - (CW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
